// File: rtl/nn_pkg.sv
// Shared types for the neuron training slice: fixed-point value types,
// sequencer state encoding, sample record and an absolute-difference helper.
package nn_pkg;

  // Width of one unsigned fixed-point value in the range [0, 1].
  localparam int ZW = 8;

  typedef logic [ZW-1:0]        zero2one_t;
  typedef logic signed [ZW-1:0] frac_t;

  // Fan-in of the default neuron. Modules that take N as a parameter build
  // their own record of matching shape.
  localparam int N_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_PERTURB = 3'd3,
    ST_NEXT    = 3'd4,
    ST_EPOCH   = 3'd5,
    ST_DONE    = 3'd6
  } train_state_e;

  typedef struct packed {
    zero2one_t [N_DEF-1:0] in;
    zero2one_t             exp;
  } sample_t;

  // Unsigned |a - b| without leaving the zero2one_t range.
  function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
    return (a >= b) ? zero2one_t'(a - b) : zero2one_t'(b - a);
  endfunction

endpackage

// File: rtl/sample_store.sv
// NS-slot register file of training samples: synchronous write port,
// combinational read port so the sequencer sees a slot the cycle it selects it.
module sample_store
  import nn_pkg::*;
#(
  parameter int N  = 16,
  parameter int NS = 8,
  localparam int SA = $clog2(NS)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [SA-1:0]          waddr,
  input  zero2one_t [N-1:0]      wr_in,
  input  zero2one_t              wr_exp,
  input  logic [SA-1:0]          raddr,
  output zero2one_t [N-1:0]      rd_in,
  output zero2one_t              rd_exp
);

  zero2one_t [N-1:0] in_slots  [NS];
  zero2one_t         exp_slots [NS];

  for (genvar gi = 0; gi < NS; gi++) begin : g_slot
    zero2one_t [N-1:0] in_reg;
    zero2one_t         exp_reg;

    // Slot contents are deliberately left unreset; the host must load them.
    always_ff @(posedge clk) begin
      if (we && (waddr == SA'(gi))) begin
        in_reg  <= wr_in;
        exp_reg <= wr_exp;
      end
    end

    assign in_slots[gi]  = in_reg;
    assign exp_slots[gi] = exp_reg;
  end

  assign rd_in  = in_slots[raddr];
  assign rd_exp = exp_slots[raddr];

endmodule

// File: rtl/neuron_train_ctrl.sv
// Training sequencer for one neuron_learn instance. Walks every stored sample
// once per epoch, accumulates |out - expected|, requests a one-cycle perturb
// on any error when learning is enabled, and stops on convergence or on the
// epoch limit.
module neuron_train_ctrl
  import nn_pkg::*;
#(
  parameter int N      = 16,
  parameter int NS     = 8,
  parameter int SETTLE = 2,
  parameter int EW     = 16,
  localparam int SA    = $clog2(NS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              learn_en,
  input  logic [15:0]       max_epochs,
  input  logic [EW-1:0]     err_thresh,
  input  logic              smp_we,
  input  logic [SA-1:0]     smp_addr,
  input  zero2one_t [N-1:0] smp_in,
  input  zero2one_t         smp_exp,
  output logic              nrn_valid,
  output logic              nrn_learn,
  output zero2one_t [N-1:0] nrn_in,
  output zero2one_t         nrn_expected_out,
  input  zero2one_t         nrn_out,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [15:0]       epoch_count,
  output logic [EW-1:0]     epoch_err
);

  // Settle counter runs 0..SETTLE-1 inside APPLY.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  train_state_e      state_reg, state_next;
  logic [SA-1:0]     idx_reg, idx_next;
  logic [SW-1:0]     settle_reg, settle_next;
  logic [EW-1:0]     acc_reg, acc_next;
  logic [15:0]       epoch_count_reg, epoch_count_next;
  logic [EW-1:0]     epoch_err_reg, epoch_err_next;
  logic              converged_reg, converged_next;
  logic [15:0]       max_ep_reg, max_ep_next;
  logic [EW-1:0]     thresh_reg, thresh_next;

  logic              ram_we;
  zero2one_t [N-1:0] rd_in;
  zero2one_t         rd_exp;
  zero2one_t         sample_err;
  logic [EW:0]       acc_wide;
  logic [EW-1:0]     acc_sat;
  logic [16:0]       ecnt_p1;

  sample_store #(
    .N  (N),
    .NS (NS)
  ) u_store (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (smp_addr),
    .wr_in  (smp_in),
    .wr_exp (smp_exp),
    .raddr  (idx_reg),
    .rd_in  (rd_in),
    .rd_exp (rd_exp)
  );

  // Error of the current sample and the saturating accumulator update.
  always_comb begin
    sample_err = abs_diff(nrn_out, rd_exp);
    acc_wide   = {1'b0, acc_reg} + {{(EW + 1 - ZW){1'b0}}, sample_err};
    acc_sat    = acc_wide[EW] ? {EW{1'b1}} : acc_wide[EW-1:0];
    ecnt_p1    = {1'b0, epoch_count_reg} + 17'd1;
  end

  // Next-state, counter updates and neuron-facing outputs.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    settle_next      = settle_reg;
    acc_next         = acc_reg;
    epoch_count_next = epoch_count_reg;
    epoch_err_next   = epoch_err_reg;
    converged_next   = converged_reg;
    max_ep_next      = max_ep_reg;
    thresh_next      = thresh_reg;
    ram_we           = 1'b0;
    nrn_valid        = 1'b1;
    nrn_learn        = 1'b0;
    nrn_in           = '0;
    nrn_expected_out = '0;
    busy             = 1'b1;
    done             = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        busy   = 1'b0;
        // A write in the start cycle lands before slot 0 is first read.
        ram_we = smp_we;
        if (start) begin
          state_next       = ST_APPLY;
          idx_next         = '0;
          settle_next      = '0;
          acc_next         = '0;
          epoch_count_next = '0;
          max_ep_next      = (max_epochs == 16'd0) ? 16'd1 : max_epochs;
          thresh_next      = err_thresh;
          converged_next   = 1'b0;
        end
      end

      ST_APPLY: begin
        nrn_in           = rd_in;
        nrn_expected_out = rd_exp;
        if (settle_reg == SW'(SETTLE - 1)) begin
          settle_next = '0;
          state_next  = ST_SAMPLE;
        end else begin
          settle_next = settle_reg + SW'(1);
        end
      end

      ST_SAMPLE: begin
        nrn_in           = rd_in;
        nrn_expected_out = rd_exp;
        acc_next         = acc_sat;
        state_next       = ((sample_err != '0) && learn_en) ? ST_PERTURB : ST_NEXT;
      end

      ST_PERTURB: begin
        nrn_in           = rd_in;
        nrn_expected_out = rd_exp;
        nrn_valid        = 1'b0;
        nrn_learn        = 1'b1;
        state_next       = ST_NEXT;
      end

      ST_NEXT: begin
        nrn_in           = rd_in;
        nrn_expected_out = rd_exp;
        if (idx_reg == SA'(NS - 1)) begin
          state_next = ST_EPOCH;
        end else begin
          idx_next   = idx_reg + SA'(1);
          state_next = ST_APPLY;
        end
      end

      ST_EPOCH: begin
        epoch_err_next   = acc_reg;
        epoch_count_next = (epoch_count_reg == 16'hFFFF) ? epoch_count_reg : ecnt_p1[15:0];
        idx_next         = '0;
        acc_next         = '0;
        // Convergence uses the completed epoch sum, before it is cleared.
        if (acc_reg <= thresh_reg) begin
          converged_next = 1'b1;
          state_next     = ST_DONE;
        end else if (ecnt_p1 >= {1'b0, max_ep_reg}) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_APPLY;
        end
      end

      ST_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      settle_reg      <= '0;
      acc_reg         <= '0;
      epoch_count_reg <= '0;
      epoch_err_reg   <= '0;
      converged_reg   <= 1'b0;
      max_ep_reg      <= 16'd1;
      thresh_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      settle_reg      <= settle_next;
      acc_reg         <= acc_next;
      epoch_count_reg <= epoch_count_next;
      epoch_err_reg   <= epoch_err_next;
      converged_reg   <= converged_next;
      max_ep_reg      <= max_ep_next;
      thresh_reg      <= thresh_next;
    end
  end

  assign converged   = converged_reg;
  assign epoch_count = epoch_count_reg;
  assign epoch_err   = epoch_err_reg;

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Bench for neuron_train_ctrl with a scripted stub neuron. Each run's
// expected outcome is computed from the stub error table and queued when the
// run is started; it is popped and compared when the DUT pulses done.
module tb_neuron_train_ctrl;
  import nn_pkg::*;

  localparam int N      = 4;
  localparam int NS     = 4;
  localparam int SETTLE = 2;
  localparam int EW     = 16;
  localparam int SA     = 2;
  localparam int EPOCH_CYC = NS * (SETTLE + 2) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              learn_en = 1'b0;
  logic [15:0]       max_epochs = '0;
  logic [EW-1:0]     err_thresh = '0;
  logic              smp_we = 1'b0;
  logic [SA-1:0]     smp_addr = '0;
  zero2one_t [N-1:0] smp_in = '0;
  zero2one_t         smp_exp = '0;
  logic              nrn_valid;
  logic              nrn_learn;
  zero2one_t [N-1:0] nrn_in;
  zero2one_t         nrn_expected_out;
  zero2one_t         nrn_out;
  logic              busy;
  logic              done;
  logic              converged;
  logic [15:0]       epoch_count;
  logic [EW-1:0]     epoch_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Per-slot error injected by the stub; lane 0 of each sample carries its slot tag.
  int stub_err [NS];

  typedef struct {
    bit conv;
    int epochs;
    int err;
    int perts;
    int cycles;
  } exp_t;
  exp_t sb_q [$];

  neuron_train_ctrl #(
    .N(N), .NS(NS), .SETTLE(SETTLE), .EW(EW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .learn_en(learn_en),
    .max_epochs(max_epochs), .err_thresh(err_thresh),
    .smp_we(smp_we), .smp_addr(smp_addr), .smp_in(smp_in), .smp_exp(smp_exp),
    .nrn_valid(nrn_valid), .nrn_learn(nrn_learn), .nrn_in(nrn_in),
    .nrn_expected_out(nrn_expected_out), .nrn_out(nrn_out),
    .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .epoch_err(epoch_err)
  );

  always #5 clk = ~clk;

  assign nrn_out = nrn_expected_out + zero2one_t'(stub_err[nrn_in[0][1:0]]);

  // Perturb-cycle monitor.
  int   pert_total  = 0;
  int   pert_double = 0;
  int   learn_bad   = 0;
  logic prev_valid  = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b1;
    end else begin
      if (nrn_valid === 1'b0) begin
        pert_total++;
        if (prev_valid === 1'b0) pert_double++;
      end
      if (nrn_learn !== ~nrn_valid) learn_bad++;
      prev_valid = nrn_valid;
    end
  end

  // Expected outcome of a complete run given the stub error table.
  function automatic exp_t model(input int th, input int mx, input bit le);
    exp_t e;
    int   sum;
    int   nz;
    int   lim;
    sum = 0;
    nz  = 0;
    for (int s = 0; s < NS; s++) begin
      sum += stub_err[s];
      if (stub_err[s] != 0) nz++;
    end
    if (sum > 65535) sum = 65535;
    lim = (mx == 0) ? 1 : mx;
    e.conv = 1'b0; e.epochs = 0; e.err = sum; e.perts = 0; e.cycles = 0;
    while (1) begin
      e.epochs++;
      if (le) e.perts += nz;
      if (sum <= th) begin e.conv = 1'b1; break; end
      if (e.epochs >= lim) break;
    end
    e.cycles = e.epochs * EPOCH_CYC + e.perts;
    return e;
  endfunction

  task automatic write_samples();
    for (int s = 0; s < NS; s++) begin
      @(negedge clk);
      smp_we   = 1'b1;
      smp_addr = SA'(s);
      for (int l = 0; l < N; l++) smp_in[l] = zero2one_t'(16 * l + s);
      smp_exp  = zero2one_t'(8'h40 + 16 * s);
    end
    @(negedge clk);
    smp_we = 1'b0;
  endtask

  task automatic run_check(input string name, input int th, input int mx, input bit le,
                           input bit wr_with_start, input bit poke_busy);
    exp_t e;
    exp_t x;
    int   p0, d0, lb0, cyc;
    bit   seen;
    e = model(th, mx, le);
    sb_q.push_back(e);
    @(negedge clk);
    err_thresh = EW'(th);
    max_epochs = 16'(mx);
    learn_en   = le;
    start      = 1'b1;
    if (wr_with_start) begin
      smp_we   = 1'b1;
      smp_addr = '0;
      smp_in   = {8'h33, 8'h22, 8'hAA, 8'h00};
      smp_exp  = 8'h40;
    end
    p0 = pert_total; d0 = pert_double; lb0 = learn_bad;
    @(negedge clk);
    start  = 1'b0;
    smp_we = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1 || nrn_in[0] !== 8'h00) begin
      miss_cnt++;
      $display("FAIL %s first_apply: busy=%b tag=%0h, required busy=1 tag=0", name, busy, nrn_in[0]);
    end
    if (wr_with_start) begin
      vec_cnt++;
      if (nrn_in[1] !== 8'hAA) begin
        miss_cnt++;
        $display("FAIL %s write_with_start: lane1=%0h, required aa", name, nrn_in[1]);
      end
    end
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (busy === 1'b1) cyc++;
      if (poke_busy && i == 5) begin
        start = 1'b1; smp_we = 1'b1; smp_addr = 2'd1;
        smp_in = {8'h77, 8'h66, 8'h55, 8'h03}; smp_exp = 8'h10;
      end
      if (poke_busy && i == 6) begin start = 1'b0; smp_we = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0; smp_we = 1'b0;
    x = sb_q.pop_front();
    vec_cnt++;
    if (!seen) begin
      miss_cnt++;
      $display("FAIL %s done_timeout: no done within 3000 cycles, required done", name);
      rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
    end else begin
      vec_cnt += 5;
      if (converged !== x.conv) begin
        miss_cnt++; $display("FAIL %s converged: got %b, required %b", name, converged, x.conv);
      end
      if (epoch_count !== 16'(x.epochs)) begin
        miss_cnt++; $display("FAIL %s epoch_count: got %0d, required %0d", name, epoch_count, x.epochs);
      end
      if (epoch_err !== EW'(x.err)) begin
        miss_cnt++; $display("FAIL %s epoch_err: got %0d, required %0d", name, epoch_err, x.err);
      end
      if (pert_total - p0 != x.perts || pert_double != d0 || learn_bad != lb0) begin
        miss_cnt++;
        $display("FAIL %s perturbs: got %0d (merged %0d, learn_bad %0d), required %0d single-cycle",
                 name, pert_total - p0, pert_double - d0, learn_bad - lb0, x.perts);
      end
      if (cyc != x.cycles) begin
        miss_cnt++; $display("FAIL %s busy_cycles: got %0d, required %0d", name, cyc, x.cycles);
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miss_cnt++; $display("FAIL %s done_width: done=%b busy=%b, required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec_cnt += 4;
    if (nrn_valid !== 1'b1 || nrn_learn !== 1'b0) begin
      miss_cnt++; $display("FAIL reset nrn: valid=%b learn=%b, required 1 0", nrn_valid, nrn_learn);
    end
    if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0) begin
      miss_cnt++; $display("FAIL reset flags: busy=%b done=%b conv=%b, required 0 0 0", busy, done, converged);
    end
    if (epoch_count !== 16'd0 || epoch_err !== '0) begin
      miss_cnt++; $display("FAIL reset counters: count=%0d err=%0d, required 0 0", epoch_count, epoch_err);
    end
    if (nrn_in !== '0 || nrn_expected_out !== '0) begin
      miss_cnt++; $display("FAIL reset nrn_data: in=%0h exp=%0h, required 0 0", nrn_in, nrn_expected_out);
    end
  endtask

  task automatic set_errs(input int e0, input int e1, input int e2, input int e3);
    stub_err[0] = e0; stub_err[1] = e1; stub_err[2] = e2; stub_err[3] = e3;
  endtask

  task automatic test_perfect();
    set_errs(0, 0, 0, 0);
    run_check("perfect", 0, 5, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_learn();
    set_errs(3, 3, 3, 3);
    run_check("learn_err3", 0, 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_eval_only();
    set_errs(3, 3, 3, 3);
    run_check("eval_only", 0, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_thresh_inclusive();
    set_errs(0, 0, 1, 0);
    run_check("thresh_incl", 1, 5, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_max_zero();
    set_errs(3, 3, 3, 3);
    run_check("max_zero", 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_perturb();
    bit hit;
    set_errs(2, 2, 2, 2);
    @(negedge clk);
    err_thresh = '0; max_epochs = 16'd3; learn_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (nrn_valid === 1'b0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    vec_cnt++;
    if (!hit) begin
      miss_cnt++; $display("FAIL rst_perturb wait: no perturb within 200 cycles, required one");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (nrn_valid !== 1'b1 || busy !== 1'b0 || epoch_count !== 16'd0 || nrn_learn !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_perturb state: valid=%b busy=%b count=%0d learn=%b, required 1 0 0 0",
               nrn_valid, busy, epoch_count, nrn_learn);
    end
    set_errs(0, 0, 0, 0);
    run_check("after_reset", 0, 4, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    write_samples();
    set_errs(0, 0, 0, 7);
    run_check("busy_poke", 0, 2, 1'b0, 1'b0, 1'b1);
    run_check("ram_intact", 0, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_errs(0, 0, 0, 0);
    test_reset();
    write_samples();
    test_perfect();
    write_samples();
    test_learn();
    test_eval_only();
    test_thresh_inclusive();
    test_max_zero();
    test_reset_mid_perturb();
    test_busy_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
